// File: rtl/lock_entry_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lock_entry_controller                                                      |
// | Turns button levels into key pulses, aborts stalled entries, and imposes   |
// | a timed lockout after repeated failed unlock attempts.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lock_entry_controller #(
  parameter int N              = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 500_000_000,
  localparam int FW            = $clog2(MAX_FAILS + 1)
) (
  input  logic          clock_i,
  input  logic          reset_ni,
  input  logic [N-1:0]  key_i,
  input  logic          lock_error_i,
  input  logic          lock_locked_i,
  output logic [N-1:0]  key_out_o,
  output logic          lock_abort_o,
  output logic          lockout_o,
  output logic          entry_active_o,
  output logic [FW-1:0] fail_count_o
);

  localparam int MAXC = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(MAXC);

  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] LO_LAST   = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [FW-1:0] FAILS_MAX = FW'(MAX_FAILS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_ENTRY   = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   timer_q;
  logic [FW-1:0]   fail_count_q;
  logic [FW-1:0]   fail_count_d;
  logic [N-1:0]    key_out_q;
  logic            lock_abort_q;
  logic            lockout_q;
  logic            entry_active_q;
  logic            lock_error_q;
  logic            lock_locked_q;
  logic            fail_evt_d;
  logic            success_evt_d;
  logic            enter_lockout_d;

  // Attempt bookkeeping: a success in the same cycle as a failure clears the count.
  always_comb begin
    fail_evt_d      = lock_error_i & ~lock_error_q & lock_locked_i;
    success_evt_d   = lock_locked_q & ~lock_locked_i;
    fail_count_d    = fail_count_q;
    if (success_evt_d) begin
      fail_count_d = '0;
    end else if (fail_evt_d && (fail_count_q != FAILS_MAX)) begin
      fail_count_d = fail_count_q + FW'(1);
    end
    enter_lockout_d = (state_q != S_LOCKOUT) && (fail_count_d == FAILS_MAX);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      fail_count_q   <= '0;
      key_out_q      <= '0;
      lock_abort_q   <= 1'b0;
      lockout_q      <= 1'b0;
      entry_active_q <= 1'b0;
      lock_error_q   <= 1'b0;
      lock_locked_q  <= 1'b0;
    end else begin
      lock_error_q  <= lock_error_i;
      lock_locked_q <= lock_locked_i;
      key_out_q     <= '0;
      lock_abort_q  <= 1'b0;

      if (state_q == S_LOCKOUT) begin
        if (timer_q == LO_LAST) begin
          timer_q      <= '0;
          fail_count_q <= '0;
          lockout_q    <= 1'b0;
          state_q      <= (key_i != '0) ? S_PRESSED : S_IDLE;
        end else begin
          timer_q <= timer_q + TW'(1);
        end
      end else if (enter_lockout_d) begin
        fail_count_q   <= fail_count_d;
        state_q        <= S_LOCKOUT;
        lockout_q      <= 1'b1;
        lock_abort_q   <= 1'b1;
        timer_q        <= '0;
        entry_active_q <= 1'b0;
      end else begin
        fail_count_q <= fail_count_d;
        case (state_q)
          S_IDLE, S_ENTRY: begin
            if (key_i != '0) begin
              // A new press always beats an expiring entry timer.
              key_out_q      <= $onehot(key_i) ? key_i : '0;
              state_q        <= S_PRESSED;
              timer_q        <= '0;
              entry_active_q <= 1'b0;
            end else if (state_q == S_ENTRY) begin
              if (timer_q == TO_LAST) begin
                lock_abort_q   <= 1'b1;
                state_q        <= S_IDLE;
                timer_q        <= '0;
                entry_active_q <= 1'b0;
              end else begin
                timer_q <= timer_q + TW'(1);
              end
            end
          end
          S_PRESSED: begin
            if (key_i == '0) begin
              state_q        <= S_ENTRY;
              timer_q        <= '0;
              entry_active_q <= 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign key_out_o      = key_out_q;
  assign lock_abort_o   = lock_abort_q;
  assign lockout_o      = lockout_q;
  assign entry_active_o = entry_active_q;
  assign fail_count_o   = fail_count_q;

endmodule
`default_nettype wire

// File: tb/tb_lock_entry_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lock_entry_controller                                                   |
// | Scoreboard bench: stimulus process predicts, monitor process compares.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lock_entry_controller;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam int MF = 2;
  localparam int LO = 16;
  localparam int FW = $clog2(MF + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  key = '0;
  logic          err = 1'b0;
  logic          lk = 1'b0;
  logic [N-1:0]  key_out;
  logic          abort;
  logic          lockout;
  logic          entry;
  logic [FW-1:0] fc;

  lock_entry_controller #(
    .N(N), .TIMEOUT_CYCLES(TO), .MAX_FAILS(MF), .LOCKOUT_CYCLES(LO)
  ) dut (
    .clock_i(clk), .reset_ni(rst_n), .key_i(key),
    .lock_error_i(err), .lock_locked_i(lk),
    .key_out_o(key_out), .lock_abort_o(abort), .lockout_o(lockout),
    .entry_active_o(entry), .fail_count_o(fc)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned  stamp;
    logic [N-1:0] key;
    logic         abort;
  } evt_t;

  typedef struct {
    int unsigned stamp;
    logic        lockout;
    logic        entry;
    int          fails;
  } st_t;

  evt_t evq[$];
  st_t  stq[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: held button, idle-cycle count since release, lockout cycles remaining.
  bit m_held, m_in_entry, m_perr, m_plk;
  int m_idle, m_left, m_fails;

  task automatic model_step(input logic [N-1:0] k, input logic e, input logic l, input logic r);
    evt_t ev;
    st_t  st;
    bit   rise, fall;
    logic [N-1:0] pulse;
    logic ab;
    pulse = '0;
    ab    = 1'b0;
    if (!r) begin
      m_held = 0; m_in_entry = 0; m_perr = 0; m_plk = 0;
      m_idle = 0; m_left = 0; m_fails = 0;
    end else begin
      rise   = e && !m_perr && l;
      fall   = m_plk && !l;
      m_perr = e;
      m_plk  = l;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_fails = 0;
          m_held  = (k != 0);
        end
      end else begin
        if (fall) m_fails = 0;
        else if (rise && m_fails < MF) m_fails++;
        if (m_fails == MF) begin
          m_left = LO; ab = 1'b1; m_in_entry = 0; m_held = 0;
        end else if (!m_held && k != 0) begin
          if ($countones(k) == 1) pulse = k;
          m_held = 1; m_in_entry = 0;
        end else if (m_held) begin
          if (k == 0) begin m_held = 0; m_in_entry = 1; m_idle = 0; end
        end else if (m_in_entry) begin
          m_idle++;
          if (m_idle == TO) begin ab = 1'b1; m_in_entry = 0; end
        end
      end
    end
    if (pulse != 0 || ab) begin
      ev.stamp = cyc + 1; ev.key = pulse; ev.abort = ab;
      evq.push_back(ev);
    end
    st.stamp = cyc + 1; st.lockout = (m_left > 0); st.entry = m_in_entry; st.fails = m_fails;
    stq.push_back(st);
  endtask

  task automatic step(input logic [N-1:0] k, input logic e, input logic l, input logic r);
    @(negedge clk);
    key = k; err = e; lk = l; rst_n = r;
    model_step(k, e, l, r);
  endtask

  task automatic steps(input int n, input logic [N-1:0] k, input logic e, input logic l);
    for (int i = 0; i < n; i++) step(k, e, l, 1'b1);
  endtask

  // Monitor
  initial begin
    forever begin
      st_t  s;
      evt_t ev;
      @(posedge clk);
      #1;
      if (stq.size() > 0) begin
        s = stq.pop_front();
        checks++;
        if (s.stamp == cyc && lockout === s.lockout && entry === s.entry && fc === FW'(s.fails))
          passes++;
        else
          $display("FAIL status cyc=%0d: got lockout=%b entry_active=%b fail_count=%0d, want lockout=%b entry_active=%b fail_count=%0d (stamp %0d)",
                   cyc, lockout, entry, fc, s.lockout, s.entry, s.fails, s.stamp);
      end
      while (evq.size() > 0 && evq[0].stamp < cyc) begin
        ev = evq.pop_front();
        checks++;
        $display("FAIL missing_pulse cyc=%0d: got nothing, want key_out=%b lock_abort=%b at cycle %0d",
                 cyc, ev.key, ev.abort, ev.stamp);
      end
      if (key_out !== '0 || abort !== 1'b0) begin
        checks++;
        if (evq.size() == 0) begin
          $display("FAIL unexpected_pulse cyc=%0d: got key_out=%b lock_abort=%b, want none",
                   cyc, key_out, abort);
        end else begin
          ev = evq.pop_front();
          if (ev.stamp == cyc && ev.key === key_out && ev.abort === abort)
            passes++;
          else
            $display("FAIL pulse cyc=%0d: got key_out=%b lock_abort=%b, want key_out=%b lock_abort=%b at cycle %0d",
                     cyc, key_out, abort, ev.key, ev.abort, ev.stamp);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [N-1:0] k;
    logic e, l, r;
    // 1: reset with a key held, then release reset
    for (int i = 0; i < 3; i++) step(4'b0010, 1'b0, 1'b0, 1'b0);
    steps(3, 4'b0010, 1'b0, 1'b0);
    steps(2, 4'b0000, 1'b0, 1'b0);
    // 2: long hold, then stall into timeout
    steps(10, 4'b0100, 1'b0, 1'b0);
    steps(12, 4'b0000, 1'b0, 1'b0);
    // 3: invalid chord, then a valid press from ENTRY
    steps(3, 4'b0101, 1'b0, 1'b0);
    steps(2, 4'b0000, 1'b0, 1'b0);
    steps(2, 4'b0001, 1'b0, 1'b0);
    steps(11, 4'b0000, 1'b0, 1'b0);
    // 4: two failures while locked trigger lockout; presses blocked
    steps(2, 4'b0000, 1'b0, 1'b1);
    steps(1, 4'b0000, 1'b1, 1'b1);
    steps(1, 4'b0000, 1'b0, 1'b1);
    steps(1, 4'b0000, 1'b1, 1'b1);
    steps(1, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) steps(2, N'(1 << (i % N)), 1'b0, 1'b1);
    steps(4, 4'b1000, 1'b1, 1'b1);
    steps(3, 4'b0000, 1'b0, 1'b1);
    // 5: failure and success in the same cycle
    steps(1, 4'b0000, 1'b1, 1'b1);
    steps(1, 4'b0000, 1'b0, 1'b1);
    steps(1, 4'b0000, 1'b1, 1'b0);
    steps(3, 4'b0000, 1'b0, 1'b0);
    // 6: reset mid-lockout and mid-entry
    steps(1, 4'b0000, 1'b0, 1'b1);
    steps(1, 4'b0000, 1'b1, 1'b1);
    steps(1, 4'b0000, 1'b0, 1'b1);
    steps(1, 4'b0000, 1'b1, 1'b1);
    steps(5, 4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1, 1'b0);
    steps(2, 4'b0000, 1'b0, 1'b0);
    steps(2, 4'b0001, 1'b0, 1'b0);
    steps(3, 4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    steps(3, 4'b0000, 1'b0, 1'b0);
    // Randomised segments
    e = 1'b0; l = 1'b0;
    for (int seg = 0; seg < 250; seg++) begin
      int sel;
      int len;
      sel = $urandom_range(0, 9);
      if (sel < 4)      k = '0;
      else if (sel < 8) k = N'(1 << $urandom_range(0, N - 1));
      else              k = N'($urandom_range(1, (1 << N) - 1));
      len = $urandom_range(1, 12);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 5) == 0) e = ~e;
        if ($urandom_range(0, 9) == 0) l = ~l;
        r = ($urandom_range(0, 199) != 0);
        step(k, e, l, r);
      end
    end
    steps(LO + TO + 4, 4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    checks++;
    if (evq.size() == 0 && stq.size() == 0)
      passes++;
    else
      $display("FAIL drain: got %0d pulses and %0d status records outstanding, want 0 and 0",
               evq.size(), stq.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
